// File: rtl/flit_injector_if.sv
// PE-to-router injection bundle: packet handshake on one side, FIFO write port on the other.
// master is the injector; slave is whatever drives it (PE + router FIFO model).
interface flit_injector_if #(
  parameter int unsigned packet_size = 32,
  parameter int unsigned flit_size   = 4
);
  logic [packet_size-1:0] packet_in;
  logic                   packet_valid;
  logic                   packet_ready;
  logic                   fifo_full;
  logic [flit_size-1:0]   flit_out;
  logic                   write_fifo;
  logic                   busy;
  logic                   packet_done;

  modport master (
    input  packet_in, packet_valid, fifo_full,
    output packet_ready, flit_out, write_fifo, busy, packet_done
  );

  modport slave (
    output packet_in, packet_valid, fifo_full,
    input  packet_ready, flit_out, write_fifo, busy, packet_done
  );
endinterface

// File: rtl/flit_injector.sv
// Serialises one parallel packet into flits, lowest flit first, and writes them into a
// router input FIFO, stalling while the FIFO is full. Back-to-back packets leave no gap.
module flit_injector #(
  parameter int unsigned packet_size  = 32,
  parameter int unsigned address_size = 16,
  parameter int unsigned flit_size    = 4
) (
  input logic            clk,
  input logic            reset,
  flit_injector_if.master bus
);

  localparam int unsigned FLITS = packet_size / flit_size;
  localparam int unsigned CNT_W = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLITS - 1);

  if (((packet_size % flit_size) != 0) || ((address_size % flit_size) != 0)) begin : g_bad_size
    $error("flit_injector: packet_size and address_size must be multiples of flit_size");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nxt;
  logic [packet_size-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]       flit_cnt, cnt_nxt;
  logic                   done_q;

  logic write_c;
  logic last_write_c;
  logic ready_c;
  logic accept_c;

  // Handshake and FIFO write are combinational on fifo_full so a free slot is never wasted.
  assign write_c      = (state == SEND) && !bus.fifo_full;
  assign last_write_c = write_c && (flit_cnt == LAST_CNT);
  assign ready_c      = !reset && ((state == IDLE) || last_write_c);
  assign accept_c     = bus.packet_valid && ready_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      flit_cnt  <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      flit_cnt  <= cnt_nxt;
      done_q    <= last_write_c;
    end
  end

  // Next state: a new packet load overrides the shift of the flit just written.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = flit_cnt;

    if (write_c) begin
      shift_nxt = shift_reg >> flit_size;
      cnt_nxt   = flit_cnt + CNT_W'(1);
      if (last_write_c) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end

    if (accept_c) begin
      shift_nxt = bus.packet_in;
      cnt_nxt   = '0;
      state_nxt = SEND;
    end
  end

  assign bus.packet_ready = ready_c;
  assign bus.write_fifo   = write_c;
  assign bus.flit_out     = shift_reg[flit_size-1:0];
  assign bus.busy         = (state == SEND);
  assign bus.packet_done  = done_q;

endmodule
